fetch_unit: RTL
===============

# fetch_unit

Instruction fetch stage for the 16-bit multi-cycle CPU, sitting directly upstream of the instruction decoder/control unit. Owns the PC, runs a request/ready handshake with instruction memory, holds the fetched word in an instruction register driven to decode, and computes the next PC from decode's jump/branch outcome when decode accepts the instruction. Also counts retired fetches.

## Interface
- WORD_SIZE, 16: instruction, address and data width.
- RESET_PC, 16'h0000: PC value loaded on reset.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- i_readM  out  1  instruction memory read request.
- i_address  out  WORD_SIZE  fetch address (= pc).
- i_data  in  WORD_SIZE  instruction word from memory; valid when i_ready.
- i_ready  in  1  memory completion strobe for the outstanding read.
- inst  out  WORD_SIZE  instruction register to decode.
- inst_valid  out  1  inst holds an unconsumed instruction.
- inst_ack  in  1  decode consumes inst this cycle; redirect inputs valid.
- pc_src1  in  1  J/JAL: target = {pc_plus1[15:12], inst[11:0]}.
- pc_src2  in  1  JPR/JRL: target = rs_data.
- branch_taken  in  1  taken branch: target = pc_plus1 + sext(inst[7:0]).
- rs_data  in  WORD_SIZE  register operand for JPR/JRL.
- halt  in  1  HLT decoded; sampled with inst_ack.
- pc_plus1  out  WORD_SIZE  pc + 1 (link value for JAL/JRL).
- num_inst  out  WORD_SIZE  count of acknowledged instructions.

## Operation
- States: BOOT, FETCH, ISSUE, HALT.
- BOOT: entered on reset; next cycle -> FETCH unconditionally.
- FETCH: i_readM=1, i_address=pc. On i_ready: ir <= i_data, -> ISSUE. Without i_ready: stay, request held stable.
- ISSUE: inst_valid=1, i_readM=0. On inst_ack: pc <= next_pc, num_inst <= num_inst+1; -> HALT if halt else FETCH. Without inst_ack: hold ir, pc unchanged.
- HALT: terminal until reset; i_readM=0, inst_valid=0, inst keeps last word, pc holds the next_pc computed at the halting ack.
- next_pc priority: pc_src2 > pc_src1 > branch_taken > pc_plus1.
- Arithmetic: all modulo 2^16; 16'hFFFF + 1 -> 16'h0000; branch offset is inst[7:0] sign-extended to 16 bits, added to pc_plus1, carry discarded.
- i_ready outside FETCH ignored; inst_ack, redirect inputs and halt outside ISSUE ignored.
- num_inst wraps 16'hFFFF -> 0.

## Timing
- Reset values (asynchronous, immediate): state=BOOT, pc=RESET_PC, ir=16'h0000, num_inst=0, i_readM=0, inst_valid=0, pc_plus1=RESET_PC+1.
- First request: i_readM high in the 2nd cycle after reset deasserts (BOOT occupies one cycle).
- i_ready may arrive in the same cycle i_readM first rises; ir captures at that edge, inst_valid high next cycle.
- Fetch-to-valid latency: 1 cycle after the i_ready edge. Ack-to-next-request: i_readM high the cycle after inst_ack; minimum throughput one instruction per 2 cycles with zero-wait memory.
- i_readM, inst_valid, i_address are decoded from registered state/pc only; no combinational path from any input to any output except none (pc_plus1 from pc).
- Reset mid-FETCH: request drops immediately; the pending i_ready after reset is ignored (state BOOT).

## Structure
- Shared in opcodes.v: `WORD_SIZE, fetch state encodings (2-bit), RESET_PC default.
- One sub-module: fetch_next_pc (combinational next-PC mux/adders: inputs pc, inst, rs_data, pc_src1, pc_src2, branch_taken; output next_pc, pc_plus1).
- Top holds FSM, pc, ir, num_inst registers.

## Test plan
- Reset, memory i_ready same cycle as request, i_data=16'h6001 -> i_readM in cycle 2, inst=16'h6001 and inst_valid in cycle 3; ack -> pc=16'h0001, num_inst=1.
- pc=16'h1234, inst=16'h9ABC, pc_src1=1 at ack -> next i_address=16'h1ABC.
- pc=16'h0010, inst low byte 16'hFE, branch_taken=1 -> pc=16'h000F; with pc_src2=1, rs_data=16'h0400 simultaneously -> pc=16'h0400.
- pc=16'hFFFF, no redirect -> pc=16'h0000; 3-cycle i_ready delay -> i_readM/i_address stable for all 3 cycles, one capture only.
- inst_valid held 5 cycles without ack -> inst, pc, num_inst unchanged; halt=1 with ack -> HALT, i_readM stays 0 for 20 cycles, spurious i_ready ignored.
- reset asserted mid-FETCH -> outputs at reset values same cycle; restart fetches from RESET_PC.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared fetch-stage width, reset PC default and FSM state encoding.
package fetch_unit_pkg;
  localparam int DEF_WORD_SIZE = 16;
  localparam logic [15:0] DEF_RESET_PC = 16'h0000;
  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_ISSUE = 2'd2,
    ST_HALT  = 2'd3
  } fetch_state_e;
endpackage

// File: rtl/fetch_unit_next_pc.sv
// fetch_next_pc: combinational next-PC selection; rs_data beats jump target beats taken branch beats pc+1.
module fetch_next_pc
  import fetch_unit_pkg::*;
#(
  parameter int WORD_SIZE = DEF_WORD_SIZE
) (
  input  logic [WORD_SIZE-1:0] pc,
  input  logic [WORD_SIZE-1:0] inst,
  input  logic [WORD_SIZE-1:0] rs_data,
  input  logic                 pc_src1,
  input  logic                 pc_src2,
  input  logic                 branch_taken,
  output logic [WORD_SIZE-1:0] next_pc,
  output logic [WORD_SIZE-1:0] pc_plus1
);
  logic [WORD_SIZE-1:0] jmp_target;
  logic [WORD_SIZE-1:0] br_target;
  assign pc_plus1   = pc + WORD_SIZE'(1);
  assign jmp_target = {pc_plus1[WORD_SIZE-1:12], inst[11:0]};
  assign br_target  = pc_plus1 + {{(WORD_SIZE-8){inst[7]}}, inst[7:0]};
  assign next_pc    = pc_src2 ? rs_data : pc_src1 ? jmp_target : branch_taken ? br_target : pc_plus1;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC, fetches over a req/ready handshake, presents the instruction register to decode
// and advances the PC with decode's redirect on acknowledge; stops for good on an acknowledged HLT.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int                   WORD_SIZE = DEF_WORD_SIZE,
  parameter logic [WORD_SIZE-1:0] RESET_PC  = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic                 i_readM,
  output logic [WORD_SIZE-1:0] i_address,
  input  logic [WORD_SIZE-1:0] i_data,
  input  logic                 i_ready,
  output logic [WORD_SIZE-1:0] inst,
  output logic                 inst_valid,
  input  logic                 inst_ack,
  input  logic                 pc_src1,
  input  logic                 pc_src2,
  input  logic                 branch_taken,
  input  logic [WORD_SIZE-1:0] rs_data,
  input  logic                 halt,
  output logic [WORD_SIZE-1:0] pc_plus1,
  output logic [WORD_SIZE-1:0] num_inst
);
  fetch_state_e         state_q, state_d;
  logic [WORD_SIZE-1:0] pc_q, pc_d;
  logic [WORD_SIZE-1:0] ir_q, ir_d;
  logic [WORD_SIZE-1:0] cnt_q, cnt_d;
  logic [WORD_SIZE-1:0] next_pc;

  fetch_next_pc #(.WORD_SIZE(WORD_SIZE)) u_next_pc (
    .pc          (pc_q),
    .inst        (ir_q),
    .rs_data     (rs_data),
    .pc_src1     (pc_src1),
    .pc_src2     (pc_src2),
    .branch_taken(branch_taken),
    .next_pc     (next_pc),
    .pc_plus1    (pc_plus1)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
    end
  end

  // Inputs not belonging to the current state are simply never looked at.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_BOOT:  state_d = ST_FETCH;
      ST_FETCH: if (i_ready) begin
        ir_d    = i_data;
        state_d = ST_ISSUE;
      end
      ST_ISSUE: if (inst_ack) begin
        pc_d    = next_pc;
        cnt_d   = cnt_q + WORD_SIZE'(1);
        state_d = halt ? ST_HALT : ST_FETCH;
      end
      default:  state_d = ST_HALT;
    endcase
  end

  assign i_readM    = (state_q == ST_FETCH);
  assign inst_valid = (state_q == ST_ISSUE);
  assign i_address  = pc_q;
  assign inst       = ir_q;
  assign num_inst   = cnt_q;
endmodule
